// File: rtl/divop_seq_if.sv
// divop_seq_if: start/operand request and busy/done/result response bundle for divop_seq
interface divop_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divop_seq.sv
// divop_seq: 32-step restoring divider (div/divu) with sign fixup and fixed 34-cycle latency
module divop_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  divop_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
  state_t           state_q, state_d;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] q_q, r_q, d_q, dvd_q, quo_q, rmd_q;
  logic             neg_q_q, neg_r_q, dz_q, dbz_q, done_q;
  logic             accept, borrow;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, diff;
  logic [WIDTH:0]   shifted;
  // the done pulse occupies the cycle after DONE, so a start there is refused too
  assign accept  = state_q == IDLE && !done_q && bus.start;
  assign dvd_mag = bus.is_signed && bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dsr_mag = bus.is_signed && bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign shifted = {r_q, q_q[WIDTH-1]};
  assign borrow  = shifted < {1'b0, d_q};
  assign diff    = shifted[WIDTH-1:0] - d_q;
  assign bus.busy        = state_q != IDLE || done_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
  // next-state selection
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (accept ? RUN : IDLE) :
              state_q == RUN   ? (cnt_q == 5'd31 ? FIXUP : RUN) :
              state_q == FIXUP ? DONE : IDLE;
  end
  // state register, step counter and visible result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DONE;
      cnt_q   <= accept ? '0 : state_q == RUN ? cnt_q + 5'd1 : cnt_q;
      if (state_q == DONE) begin
        quo_q <= dz_q ? '1 : q_q;
        rmd_q <= dz_q ? dvd_q : r_q;
        dbz_q <= dz_q;
      end
    end
  end
  // operand latch, restoring shift/subtract steps and sign fixup
  always_ff @(posedge clk) begin
    if (accept) begin
      q_q     <= dvd_mag;
      d_q     <= dsr_mag;
      r_q     <= '0;
      dvd_q   <= bus.dividend;
      dz_q    <= bus.divisor == '0;
      neg_q_q <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      neg_r_q <= bus.is_signed && bus.dividend[WIDTH-1];
    end else if (state_q == RUN) begin
      r_q <= borrow ? shifted[WIDTH-1:0] : diff;
      q_q <= {q_q[WIDTH-2:0], ~borrow};
    end else if (state_q == FIXUP) begin
      q_q <= neg_q_q ? -q_q : q_q;
      r_q <= neg_r_q ? -r_q : r_q;
    end
  end
endmodule
